// File: rtl/sw_chain_evaluator.sv
// Cascaded switch/LED chain evaluator: synchronised (optionally debounced) switches,
// one stage per cycle. Optional debounce is enabled by defining SW_DEBOUNCE_EN.
module sw_chain_evaluator #(
    parameter int STAGES          = 2,
    parameter int IN_PER_STAGE    = 3,
    parameter int DEBOUNCE_CYCLES = 16,
    localparam int W              = STAGES * IN_PER_STAGE + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [W-1:0]      sw,
    input  logic [1:0]        mode,
    output logic [STAGES-1:0] led,
    output logic              busy,
    output logic              done
);

    localparam int NI = IN_PER_STAGE + 1;
    localparam int IW = (STAGES > 1) ? $clog2(STAGES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        DONE = 2'd2
    } state_e;

    logic [W-1:0]      sw_meta_q, sw_sync_q, sw_s_q;
    logic [1:0]        mode_meta_q, mode_sync_q, mode_s_q;
    logic              launch_q;
    logic              sw_launch_s;
    logic [W-1:0]      snap_sw_q, snap_sw_d;
    logic [1:0]        snap_mode_q, snap_mode_d;
    state_e            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              pending_q, pending_d;
    logic [STAGES-1:0] led_q, led_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [NI-1:0]     stage_in_s;

    function automatic logic stage_fn(input logic [1:0] m, input logic [NI-1:0] v);
        int ones;
        ones = 0;
        for (int i = 0; i < NI; i++) begin
            ones += int'(v[i]);
        end
        case (m)
            2'b00:   stage_fn = &v;
            2'b01:   stage_fn = |v;
            2'b10:   stage_fn = ^v;
            2'b11:   stage_fn = (ones > NI / 2);
            default: stage_fn = 1'b0;
        endcase
    endfunction

    // Two-flop synchronisers for the asynchronous switch and mode inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta_q   <= '0;
            sw_sync_q   <= '0;
            mode_meta_q <= 2'b00;
            mode_sync_q <= 2'b00;
        end else begin
            sw_meta_q   <= sw;
            sw_sync_q   <= sw_meta_q;
            mode_meta_q <= mode;
            mode_sync_q <= mode_meta_q;
        end
    end

`ifdef SW_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [W-1:0]  cand_q;
    logic [CW-1:0] cnt_q;

    // Accept only a candidate that stayed unchanged for the full debounce window.
    assign sw_launch_s = (sw_sync_q == cand_q) && (cnt_q == CW'(DEBOUNCE_CYCLES - 1))
                         && (cand_q != sw_s_q);

    // Debounce candidate, saturating stability counter and accepted switch vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_q <= '0;
            cnt_q  <= '0;
            sw_s_q <= '0;
        end else begin
            if (sw_sync_q != cand_q) begin
                cand_q <= sw_sync_q;
                cnt_q  <= '0;
            end else if (cnt_q != CW'(DEBOUNCE_CYCLES)) begin
                cnt_q <= cnt_q + CW'(1);
            end
            if (sw_launch_s) begin
                sw_s_q <= cand_q;
            end
        end
    end
`else
    assign sw_launch_s = (sw_sync_q != sw_s_q);

    // Without debounce the stable vector simply follows the synchroniser.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_s_q <= '0;
        end else begin
            sw_s_q <= sw_sync_q;
        end
    end
`endif

    // Mode register and launch pulse, aligned with the cycle the new value is visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_s_q <= 2'b00;
            launch_q <= 1'b0;
        end else begin
            mode_s_q <= mode_sync_q;
            launch_q <= sw_launch_s || (mode_sync_q != mode_s_q);
        end
    end

    // FSM next state; led_q doubles as the per-stage result chain r[].
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        pending_d   = pending_q;
        snap_sw_d   = snap_sw_q;
        snap_mode_d = snap_mode_q;
        led_d       = led_q;
        stage_in_s  = snap_sw_q[idx_q * IN_PER_STAGE +: NI];
        if (idx_q != '0) begin
            stage_in_s[0] = led_q[idx_q - IW'(1)];
        end else begin
            stage_in_s[0] = snap_sw_q[0];
        end
        case (state_q)
            IDLE: begin
                if (launch_q || pending_q) begin
                    state_d     = EVAL;
                    snap_sw_d   = sw_s_q;
                    snap_mode_d = mode_s_q;
                    idx_d       = '0;
                    pending_d   = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            EVAL: begin
                led_d[idx_q] = stage_fn(snap_mode_q, stage_in_s);
                if (launch_q) begin
                    pending_d = 1'b1;
                end else begin
                    pending_d = pending_q;
                end
                if (idx_q == IW'(STAGES - 1)) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            DONE: begin
                if (launch_q) begin
                    pending_d = 1'b1;
                end else begin
                    pending_d = pending_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // FSM, snapshot and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            pending_q   <= 1'b0;
            snap_sw_q   <= '0;
            snap_mode_q <= 2'b00;
            led_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            pending_q   <= pending_d;
            snap_sw_q   <= snap_sw_d;
            snap_mode_q <= snap_mode_d;
            led_q       <= led_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign led  = led_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
